// File: rtl/cpu_bus_pkg.sv
// Shared constants for the CPU datapath bus: arbitration modes, default sizing
// and the standard bus source map.
package cpu_bus_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_SRC = 24;

  localparam int SRC_R0     = 0;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational masked priority picker: first set request at or above 'start',
// wrapping at NUM_SRC (which need not be a power of two).
module bus_rr_pick #(
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  always_comb begin
    int unsigned pos;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      pos = int'(start) + k;
      if (pos >= NUM_SRC) pos = pos - NUM_SRC;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = SEL_W'(pos);
      end
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Registered datapath bus: arbitrates among drive requests, registers the
// winning word with a bus keeper, and tracks multi-driver conflicts.
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_SRC  = DEF_NUM_SRC,
  parameter int SEL_W    = $clog2(NUM_SRC),
  parameter int ARB_MODE = ARB_FIXED,
  parameter int CNT_W    = 8
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [NUM_SRC-1:0]       drive_req,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     conflict_clr,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [SEL_W-1:0]         bus_sel,
  output logic [NUM_SRC-1:0]       grant,
  output logic                     conflict,
  output logic [CNT_W-1:0]         conflict_cnt
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] win;
  logic             found;
  logic             multi;
  logic [SEL_W-1:0] ptr_next;

  assign start = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

  bus_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req   (drive_req),
    .start (start),
    .idx   (win),
    .found (found)
  );

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign multi    = |(drive_req & (drive_req - NUM_SRC'(1)));
  assign ptr_next = (32'(win) == NUM_SRC - 1) ? '0 : win + SEL_W'(1);

  always_ff @(posedge clock) begin
    if (clear) begin
      bus_out      <= '0;
      bus_valid    <= 1'b0;
      bus_sel      <= '0;
      grant        <= '0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
      rr_ptr       <= '0;
    end else begin
      bus_valid <= found;
      if (found) begin
        bus_out <= src_data[32'(win)*WIDTH +: WIDTH];
        bus_sel <= win;
        grant   <= NUM_SRC'(1) << win;
        if (ARB_MODE == ARB_RR) rr_ptr <= ptr_next;
      end else begin
        grant <= '0;
      end
      // A clear coinciding with a conflict still records that conflict.
      if (conflict_clr) begin
        conflict     <= multi;
        conflict_cnt <= multi ? CNT_W'(1) : '0;
      end else if (multi) begin
        conflict <= 1'b1;
        if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: fixed-priority and round-robin instances share
// stimulus and are checked every cycle against a behavioural model.
module tb_cpu_bus_arbiter;
  import cpu_bus_pkg::*;

  localparam int W  = 32;
  localparam int N  = 24;
  localparam int SW = $clog2(N);
  localparam int CW = 8;

  logic           clock = 1'b0;
  logic           clear;
  logic [N-1:0]   drive_req;
  logic [N*W-1:0] src_data;
  logic           conflict_clr;

  logic [W-1:0]  bus_o  [2];
  logic          val_o  [2];
  logic [SW-1:0] sel_o  [2];
  logic [N-1:0]  gnt_o  [2];
  logic          conf_o [2];
  logic [CW-1:0] cnt_o  [2];

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  always #5 clock = ~clock;

  cpu_bus_arbiter #(.WIDTH(W), .NUM_SRC(N), .ARB_MODE(ARB_FIXED), .CNT_W(CW)) dut_fx (
    .clock(clock), .clear(clear), .drive_req(drive_req), .src_data(src_data),
    .conflict_clr(conflict_clr), .bus_out(bus_o[0]), .bus_valid(val_o[0]),
    .bus_sel(sel_o[0]), .grant(gnt_o[0]), .conflict(conf_o[0]), .conflict_cnt(cnt_o[0]));

  cpu_bus_arbiter #(.WIDTH(W), .NUM_SRC(N), .ARB_MODE(ARB_RR), .CNT_W(CW)) dut_rr (
    .clock(clock), .clear(clear), .drive_req(drive_req), .src_data(src_data),
    .conflict_clr(conflict_clr), .bus_out(bus_o[1]), .bus_valid(val_o[1]),
    .bus_sel(sel_o[1]), .grant(gnt_o[1]), .conflict(conf_o[1]), .conflict_cnt(cnt_o[1]));

  // Model state, index 0 = fixed priority, 1 = round-robin
  logic [W-1:0] m_bus  [2];
  bit           m_val  [2];
  int           m_sel  [2];
  logic [N-1:0] m_gnt  [2];
  bit           m_conf [2];
  int           m_cnt  [2];
  int           m_ptr  [2];

  function automatic int pick(input logic [N-1:0] req, input int from);
    for (int k = 0; k < N; k++)
      if (req[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  always @(posedge clock) begin
    for (int m = 0; m < 2; m++) begin
      if (clear) begin
        m_bus[m] = '0; m_val[m] = 0; m_sel[m] = 0; m_gnt[m] = '0;
        m_conf[m] = 0; m_cnt[m] = 0; m_ptr[m] = 0;
      end else begin
        int w;
        bit many;
        w = pick(drive_req, (m == 1) ? m_ptr[m] : 0);
        if (w >= 0) begin
          m_bus[m] = src_data[w*W +: W];
          m_sel[m] = w;
          m_gnt[m] = '0;
          m_gnt[m][w] = 1'b1;
          m_val[m] = 1;
          if (m == 1) m_ptr[m] = (w + 1) % N;
        end else begin
          m_val[m] = 0;
          m_gnt[m] = '0;
        end
        many = $countones(drive_req) > 1;
        if (conflict_clr) begin
          m_conf[m] = many;
          m_cnt[m]  = many ? 1 : 0;
        end else if (many) begin
          m_conf[m] = 1;
          if (m_cnt[m] < (1 << CW) - 1) m_cnt[m] = m_cnt[m] + 1;
        end
      end
    end
    if (clear) armed = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (armed) begin
      for (int m = 0; m < 2; m++) begin
        chk(m ? "rr.bus_out" : "fx.bus_out", 64'(bus_o[m]), 64'(m_bus[m]));
        chk(m ? "rr.bus_valid" : "fx.bus_valid", 64'(val_o[m]), 64'(m_val[m]));
        chk(m ? "rr.bus_sel" : "fx.bus_sel", 64'(sel_o[m]), 64'(m_sel[m]));
        chk(m ? "rr.grant" : "fx.grant", 64'(gnt_o[m]), 64'(m_gnt[m]));
        chk(m ? "rr.conflict" : "fx.conflict", 64'(conf_o[m]), 64'(m_conf[m]));
        chk(m ? "rr.conflict_cnt" : "fx.conflict_cnt", 64'(cnt_o[m]), 64'(m_cnt[m]));
      end
    end
  end

  task automatic rand_data();
    for (int i = 0; i < N; i++) src_data[i*W +: W] = $urandom;
  endtask

  // Drive one request cycle, then wait for the edge that samples it.
  task automatic cyc(input logic [N-1:0] req);
    rand_data();
    drive_req = req;
    @(negedge clock);
  endtask

  initial begin
    clear = 1'b1; conflict_clr = 1'b0;
    drive_req = N'($urandom); rand_data();
    @(negedge clock);
    drive_req = N'($urandom); rand_data(); conflict_clr = 1'($urandom);
    @(negedge clock);
    conflict_clr = 1'b0;
    chk("reset.bus_out", 64'(bus_o[0]), 64'h0);
    chk("reset.bus_valid", 64'(val_o[0]), 64'h0);
    chk("reset.bus_sel", 64'(sel_o[1]), 64'h0);
    chk("reset.grant", 64'(gnt_o[1]), 64'h0);
    chk("reset.conflict", 64'(conf_o[0]), 64'h0);
    chk("reset.conflict_cnt", 64'(cnt_o[0]), 64'h0);

    clear = 1'b0;
    rand_data(); src_data[SRC_PC*W +: W] = 32'hDEADBEEF; drive_req = N'(1) << SRC_PC;
    @(negedge clock);
    chk("pc.bus_out", 64'(bus_o[0]), 64'hDEADBEEF);
    chk("pc.bus_sel", 64'(sel_o[0]), 64'd20);
    chk("pc.grant", 64'(gnt_o[0]), 64'h10_0000);
    chk("pc.bus_valid", 64'(val_o[0]), 64'h1);

    rand_data(); src_data[5*W +: W] = 32'h12345678; drive_req = N'(1) << 5;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      cyc('0);
      chk("keep.bus_out", 64'(bus_o[0]), 64'h12345678);
      chk("keep.bus_sel", 64'(sel_o[1]), 64'd5);
      chk("keep.bus_valid", 64'(val_o[0]), 64'h0);
      chk("keep.grant", 64'(gnt_o[0]), 64'h0);
    end

    cyc(24'h000088);
    chk("prio.bus_sel", 64'(sel_o[0]), 64'd3);
    chk("prio.conflict", 64'(conf_o[0]), 64'h1);
    chk("prio.conflict_cnt", 64'(cnt_o[0]), 64'd1);
    repeat (299) cyc(24'h000088);
    chk("sat.conflict_cnt", 64'(cnt_o[0]), 64'd255);
    conflict_clr = 1'b1; cyc('0); conflict_clr = 1'b0;
    chk("cclr.conflict", 64'(conf_o[0]), 64'h0);
    chk("cclr.conflict_cnt", 64'(cnt_o[0]), 64'd0);

    repeat (4) cyc(24'h000088);
    chk("pre_clr.conflict_cnt", 64'(cnt_o[0]), 64'd4);
    conflict_clr = 1'b1; cyc(24'h000003); conflict_clr = 1'b0;
    chk("clr_conf.conflict", 64'(conf_o[0]), 64'h1);
    chk("clr_conf.conflict_cnt", 64'(cnt_o[0]), 64'd1);

    clear = 1'b1; cyc('0); clear = 1'b0;
    cyc(24'h800204); chk("rr.order0", 64'(sel_o[1]), 64'd2);
    cyc(24'h800204); chk("rr.order1", 64'(sel_o[1]), 64'd9);
    cyc(24'h800204); chk("rr.order2", 64'(sel_o[1]), 64'd23);
    cyc(24'h800204); chk("rr.order3", 64'(sel_o[1]), 64'd2);
    cyc('0);
    cyc(24'h000204);
    chk("rr.after_idle", 64'(sel_o[1]), 64'd9);
    chk("fx.after_idle", 64'(sel_o[0]), 64'd2);

    cyc(N'(1) << 1);
    chk("mid.r1", 64'(sel_o[0]), 64'd1);
    clear = 1'b1; cyc(N'(1) << 2); clear = 1'b0;
    chk("mid.clr_bus", 64'(bus_o[0]), 64'h0);
    chk("mid.clr_valid", 64'(val_o[0]), 64'h0);
    chk("mid.clr_grant", 64'(gnt_o[1]), 64'h0);
    cyc(N'(1) << 3);
    chk("mid.r3_sel", 64'(sel_o[0]), 64'd3);
    chk("mid.r3_valid", 64'(val_o[0]), 64'h1);
    clear = 1'b1; cyc('0); clear = 1'b0;
    cyc(24'h000011);
    chk("mid.rr_ptr_reset", 64'(sel_o[1]), 64'd0);

    cyc('0);
    cyc('0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
